// File: rtl/two_by_one_mux_arbiter_pkg.sv
// Shared definitions for the two_by_one_mux round-robin arbiter:
// state encoding, mux select constants and the hold-budget legality check.
package two_by_one_mux_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_X = 2'b01,
        ST_GNT_Y = 2'b10
    } arb_state_e;

    // Same select convention as two_by_one_mux: 0 routes x_in, 1 routes y_in.
    localparam logic SEL_X = 1'b0;
    localparam logic SEL_Y = 1'b1;

    function automatic logic hold_cfg_ok(input int unsigned hold_max,
                                         input int unsigned cnt_w);
        logic ok;
        ok = (hold_max >= 1) && (cnt_w >= 1) && (cnt_w < 32);
        if (ok) begin
            ok = (hold_max <= (32'd1 << cnt_w));
        end
        return ok;
    endfunction

endpackage

// File: rtl/two_by_one_mux_arbiter_hold_counter.sv
// Beat counter for the current grant holder: counts accepted beats, wraps at
// HOLD_MAX-1 and flags the terminal count so the arbiter can end a burst.
module two_by_one_mux_arbiter_hold_counter
    import two_by_one_mux_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Explicit wrap at TC_VAL because HOLD_MAX need not be a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            if (cnt_q == TC_VAL) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/two_by_one_mux_arbiter.sv
// Round-robin arbiter driving the two_by_one_mux select: bounded bursts per
// requester, back-to-back switching, all grant/select outputs registered.
module two_by_one_mux_arbiter
    import two_by_one_mux_arbiter_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_x_in,
    input  logic req_y_in,
    input  logic ready_in,
    output logic sel_out,
    output logic gnt_x_out,
    output logic gnt_y_out,
    output logic xfer_out
);

    if (!hold_cfg_ok(HOLD_MAX, CNT_W)) begin : g_cfg_bad
        $error("two_by_one_mux_arbiter: HOLD_MAX must be in 1..2**CNT_W");
    end

    arb_state_e state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       sel_q, sel_d;
    logic       cnt_en;
    logic       cnt_clr;
    logic       cnt_tc;

    two_by_one_mux_arbiter_hold_counter #(
        .HOLD_MAX (HOLD_MAX),
        .CNT_W    (CNT_W)
    ) u_hold_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (cnt_en),
        .clr_i (cnt_clr),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_x_in && req_y_in) begin
                    state_d = (ptr_q == SEL_Y) ? ST_GNT_Y : ST_GNT_X;
                end else if (req_x_in) begin
                    state_d = ST_GNT_X;
                end else if (req_y_in) begin
                    state_d = ST_GNT_Y;
                end
            end

            ST_GNT_X: begin
                if (!req_x_in || (cnt_tc && ready_in && req_y_in)) begin
                    ptr_d   = SEL_Y;
                    cnt_clr = 1'b1;
                    state_d = req_y_in ? ST_GNT_Y : ST_IDLE;
                end else begin
                    cnt_en = ready_in;
                end
            end

            ST_GNT_Y: begin
                if (!req_y_in || (cnt_tc && ready_in && req_x_in)) begin
                    ptr_d   = SEL_X;
                    cnt_clr = 1'b1;
                    state_d = req_x_in ? ST_GNT_X : ST_IDLE;
                end else begin
                    cnt_en = ready_in;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_clr = 1'b1;
            end
        endcase

        // Select follows the next grant; IDLE keeps the last routed side.
        case (state_d)
            ST_GNT_X: sel_d = SEL_X;
            ST_GNT_Y: sel_d = SEL_Y;
            default:  sel_d = sel_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= SEL_X;
            sel_q   <= SEL_X;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    assign sel_out   = sel_q;
    assign gnt_x_out = (state_q == ST_GNT_X);
    assign gnt_y_out = (state_q == ST_GNT_Y);
    assign xfer_out  = (gnt_x_out | gnt_y_out) & ready_in;

endmodule
